// File: rtl/program_loader.sv
// Packs 3-bit-opcode instruction fields into 9-bit words and writes them sequentially into instruction memory.
// Latency: a bundle handshake in cycle N gives im_we in cycle N+1. Peak rate is one word per two cycles.
// Backpressure: in_ready is high only in ACCEPT and drops during each write. After done or overflow, no bundle is accepted until the next start.
//
// Ports: clk/rst_n (async active-low); start + base_addr open a session;
//   in_valid/in_ready + in_op/in_ra/in_imm/in_target/in_last carry field bundles;
//   im_we/im_addr/im_wdata drive the instruction ROM write port;
//   busy/done/overflow/count report session status.
// Optional: define LOADER_CHECKSUM_EN to add a checksum output (XOR of words written).
module program_loader #(
  parameter int MCODEBITS = 3,
  parameter int OPND_W    = 6,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [MCODEBITS-1:0]        in_op,
  input  logic [2:0]                  in_ra,
  input  logic [2:0]                  in_imm,
  input  logic [OPND_W-1:0]           in_target,
  input  logic                        in_last,
  output logic                        im_we,
  output logic [ADDR_W-1:0]           im_addr,
  output logic [MCODEBITS+OPND_W-1:0] im_wdata,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
`ifdef LOADER_CHECKSUM_EN
  output logic [ADDR_W:0]             count,
  output logic [MCODEBITS+OPND_W-1:0] checksum
`else
  output logic [ADDR_W:0]             count
`endif
);

  localparam int WORD_W = MCODEBITS + OPND_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state, next_state;
  logic [ADDR_W-1:0]   addr;
  logic                last_q;
  logic                start_fire;
  logic                hs;
  logic                at_end;
  logic [WORD_W-1:0]   enc_word;

  // Jump carries a full-width target; all other opcodes pack ra and imm.
  always_comb begin
    enc_word = {in_op, OPND_W'({in_ra, in_imm})};
    if (in_op == {MCODEBITS{1'b1}}) begin
      enc_word = {in_op, in_target};
    end
  end

  assign start_fire = (state == IDLE) && start;
  assign hs         = (state == ACCEPT) && in_valid;
  assign at_end     = (addr == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Status outputs decode straight from state, so they fall with the async reset.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    im_we      = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next_state = ACCEPT;
      end
      ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) next_state = WRITE;
      end
      WRITE: begin
        im_we = 1'b1;
        if (last_q || at_end) next_state = DONE;
        else                  next_state = ACCEPT;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // im_addr/im_wdata are loaded only on handshake, so they hold after the write
  // while the running address counter moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      last_q   <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (start_fire) begin
        addr     <= base_addr;
        count    <= '0;
        overflow <= 1'b0;
      end
      if (hs) begin
        im_addr  <= addr;
        im_wdata <= enc_word;
        last_q   <= in_last;
      end
      if (state == WRITE) begin
        addr  <= addr + 1'b1;
        count <= count + 1'b1;
        if (!last_q && at_end) overflow <= 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (start_fire) begin
      checksum <= '0;
    end else if (state == WRITE) begin
      checksum <= checksum ^ im_wdata;
    end
  end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader with a field-level reference model.
// Drives and samples on the falling clock edge; the DUT acts on the rising edge.
// Summary line reports the error count and the total check count.
module tb_program_loader;

  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] base_addr;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [2:0] in_ra;
  logic [2:0] in_imm;
  logic [5:0] in_target;
  logic       in_last;
  logic       im_we;
  logic [7:0] im_addr;
  logic [8:0] im_wdata;
  logic       busy;
  logic       done;
  logic       overflow;
  logic [8:0] count;
`ifdef LOADER_CHECKSUM_EN
  logic [8:0] checksum;
`endif

  program_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_ra(in_ra),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .busy(busy),
    .done(done), .overflow(overflow),
`ifdef LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Field-level encoding: op in the top three bits, then target or ra:imm.
  function automatic logic [8:0] enc(input int op, input int ra, input int imm, input int tgt);
    if (op == 7) return 9'(op * 64 + tgt);
    return 9'(op * 64 + ra * 8 + imm);
  endfunction

  // Write monitor.
  logic [7:0] mon_addr[$];
  logic [8:0] mon_data[$];
  int         done_cnt = 0;
  logic       prev_we = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (im_we) begin
        mon_addr.push_back(im_addr);
        mon_data.push_back(im_wdata);
        check("rdy_low_in_write", 32'(in_ready), 32'd0);
      end
      if (done) begin
        done_cnt++;
        check("done_after_write", 32'(prev_we), 32'd1);
      end
      prev_we = im_we;
    end else begin
      prev_we = 1'b0;
    end
  end

  // Bundle fields for one session (filled randomly or by directed tests).
  int f_op[16], f_ra[16], f_imm[16], f_tgt[16];

  task automatic run_session(input int base, input int n, input int last_idx,
                             input int gap_lo, input int gap_hi, input bit rnd);
    logic [8:0] exp_w[$];
    logic [8:0] ck;
    bit         exp_ovf;
    int         done0, k, gap;
    bit         acc;
    mon_addr.delete();
    mon_data.delete();
    done0   = done_cnt;
    exp_ovf = 1'b0;
    ck      = '0;
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        f_op[i]  = $urandom_range(0, 7);
        f_ra[i]  = $urandom_range(0, 7);
        f_imm[i] = $urandom_range(0, 7);
        f_tgt[i] = $urandom_range(0, 63);
      end
    end
    // Reference: bundle i lands at base+i; stop at the last bundle, or overflow at the top word.
    for (int i = 0; i < n; i++) begin
      exp_w.push_back(enc(f_op[i], f_ra[i], f_imm[i], f_tgt[i]));
      ck = ck ^ exp_w[i];
      if (i == last_idx) break;
      if (base + i == DEPTH - 1) begin
        exp_ovf = 1'b1;
        break;
      end
    end

    @(negedge clk);
    start = 1'b1;
    base_addr = 8'(base);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(gap_lo, gap_hi);
      for (int g = 0; g < gap; g++) begin
        // Stray start pulses while a session is still open must be ignored.
        if (i < exp_w.size() && $urandom_range(0, 3) == 0) begin
          start = 1'b1;
          base_addr = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        start = 1'b0;
      end
      in_op = 3'(f_op[i]);
      in_ra = 3'(f_ra[i]);
      in_imm = 3'(f_imm[i]);
      in_target = 6'(f_tgt[i]);
      in_last = (i == last_idx);
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 30) begin
        @(negedge clk);
        k++;
      end
      acc = in_ready;
      if (acc) @(negedge clk);
      in_valid = 1'b0;
      in_last = 1'b0;
      check("accepted", 32'(acc), 32'(i < exp_w.size()));
      if (!acc) break;
    end
    k = 0;
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("idle_at_end", 32'(busy), 32'd0);
    check("nwrites", 32'(mon_addr.size()), 32'(exp_w.size()));
    for (int j = 0; j < exp_w.size() && j < mon_addr.size(); j++) begin
      check("waddr", 32'(mon_addr[j]), 32'(base + j));
      check("wdata", 32'(mon_data[j]), 32'(exp_w[j]));
    end
    check("count", 32'(count), 32'(exp_w.size()));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("done_pulses", 32'(done_cnt - done0), 32'd1);
    check("addr_hold", 32'(im_addr), 32'(base + exp_w.size() - 1));
    check("data_hold", 32'(im_wdata), 32'(exp_w[exp_w.size()-1]));
`ifdef LOADER_CHECKSUM_EN
    check("checksum", 32'(checksum), 32'(ck));
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, 32'(im_we), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rdy"}, 32'(in_ready), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_addr"}, 32'(im_addr), 32'd0);
    check({tag, "_data"}, 32'(im_wdata), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    in_valid = 1'b0;
    in_op = '0;
    in_ra = '0;
    in_imm = '0;
    in_target = '0;
    in_last = 1'b0;
    #12;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    // addi ra=2 imm=5 at base 0x10.
    f_op[0] = 2; f_ra[0] = 2; f_imm[0] = 5; f_tgt[0] = 0;
    run_session(16, 1, 0, 0, 0, 1'b0);
    check("addi_word", 32'(im_wdata), 32'h095);

    // j target 0x2A at base 0; ra/imm are ignored.
    f_op[0] = 7; f_ra[0] = $urandom_range(0, 7); f_imm[0] = $urandom_range(0, 7); f_tgt[0] = 'h2A;
    run_session(0, 1, 0, 0, 0, 1'b0);
    check("j_word", 32'(im_wdata), 32'h1EA);

    // Three bundles with 3-cycle gaps.
    run_session(0, 3, 2, 3, 3, 1'b1);

    // Overflow at the top of memory; the third bundle is never accepted.
    run_session(DEPTH - 2, 3, -1, 0, 2, 1'b1);

    // start and in_valid together in IDLE: the bundle waits for ACCEPT.
    @(negedge clk);
    start = 1'b1;
    base_addr = 8'h05;
    in_valid = 1'b1;
    in_op = 3'd1;
    in_ra = 3'd3;
    in_imm = 3'd4;
    in_last = 1'b1;
    check("same_cycle_rdy0", 32'(in_ready), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("same_cycle_rdy1", 32'(in_ready), 32'd1);
    check("same_cycle_nowe", 32'(im_we), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    check("same_cycle_we", 32'(im_we), 32'd1);
    check("same_cycle_addr", 32'(im_addr), 32'h05);
    check("same_cycle_data", 32'(im_wdata), 32'h05C);
    repeat (3) @(negedge clk);

`ifdef LOADER_CHECKSUM_EN
    f_op[0] = 2; f_ra[0] = 4; f_imm[0] = 5; f_tgt[0] = 0;
    f_op[1] = 7; f_ra[1] = 0; f_imm[1] = 0; f_tgt[1] = 'h30;
    run_session(0, 2, 1, 0, 1, 1'b0);
    check("checksum_fixed", 32'(checksum), 32'h155);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("checksum_clear", 32'(checksum), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // Reset during WRITE abandons the session and clears outputs asynchronously.
    @(negedge clk);
    start = 1'b1;
    base_addr = 8'h40;
    @(negedge clk);
    start = 1'b0;
    in_op = 3'd6;
    in_ra = 3'd1;
    in_imm = 3'd2;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_reset_we", 32'(im_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("mid_write_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random sessions.
    for (int s = 0; s < 14; s++) begin
      int n, base;
      n = $urandom_range(1, 8);
      base = (s % 4 == 3) ? $urandom_range(DEPTH - 6, DEPTH - 1) : $urandom_range(0, DEPTH - 1);
      run_session(base, n, n - 1, 0, 3, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
